piso_shift_n: RTL and testbench
===============================

# piso_shift_n

Parametrised parallel-in/serial-out shift register, the next generation of the 8-bit 74HC165-style block. It adds a configurable word width, a selectable bit order, a valid/ready load handshake, and a frame counter that flags the last bit. It feeds serial links and LED/display daisy-chains from the parallel datapath. The 165-style signals are kept for cascading: active-low CE, serial Ds input, and complementary Y/Yn outputs.

## Interface
- WIDTH, 8, word length in bits; legal values are 2..32.
- MSB_FIRST, 1, bit order: 1 shifts D[WIDTH-1] out first, 0 shifts D[0] out first.
- CP  in  1  clock; all state changes on the rising edge.
- MR  in  1  reset, asynchronous, active-high. Clears all state immediately.
- CE  in  1  shift enable, active-low. CE=1 freezes the register and the counter.
- Ds  in  1  serial input; fills the vacated end on every shift (cascade input).
- D  in  WIDTH  parallel word to load.
- D_VALID  in  1  a load word is present on D.
- D_READY  out  1  the block accepts D this cycle.
- Y  out  1  serial output: the current output-end bit of the register.
- Yn  out  1  complement of Y.
- BUSY  out  1  a frame is being shifted (state SHIFT).
- LAST  out  1  Y currently carries the final bit of the frame.

## Operation
- State register Q[WIDTH-1:0]. Output end is Q[WIDTH-1] when MSB_FIRST=1, Q[0] when MSB_FIRST=0. Ds enters at the opposite end.
- Bit counter CNT holds the remaining bits minus one. Its width is clog2(WIDTH).
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - D_READY=1.
  - D_VALID=1: Q<=D, CNT<=WIDTH-1, go to SHIFT. A load overrides CE.
  - Otherwise, CE=0: Q shifts one place, Ds in. This is 165-compatible free shifting; CNT does not change.
- SHIFT:
  - CE=0 and CNT>0: Q shifts one place, CNT decrements.
  - CE=0 and CNT==0: the frame ends.
    - D_VALID=1: load the new word and stay in SHIFT (back-to-back, no gap bit).
    - D_VALID=0: shift once and go to IDLE.
  - CE=1: everything holds.
- D_READY is combinational: (state==IDLE) | (state==SHIFT & CNT==0 & CE==0).
- LAST = (state==SHIFT) & (CNT==0).
- BUSY = (state==SHIFT).
- Y is driven directly from the output-end flop, with no output logic after it. Yn = ~Y.
- D_VALID without D_READY is ignored; D is not held internally. The upstream block must keep D_VALID asserted until it sees D_READY.

## Timing
- Reset values while MR=1: Q=0, CNT=0, state=IDLE, Y=0, Yn=1, BUSY=0, LAST=0, D_READY=1.
- Load latency: Y shows the first bit in the cycle after the accepting edge.
- Each subsequent bit takes one CE=0 cycle. A frame with no stalls occupies exactly WIDTH cycles of BUSY=1.
- LAST is high for the one or more cycles Y carries bit WIDTH of the frame. It stays high while CE=1 stalls the frame.
- Back-to-back: the first bit of the next word appears in the cycle immediately after the last bit of the current word.
- MR asserted mid-frame aborts the frame: outputs go to their reset values immediately, with no LAST pulse. After MR is released, the first active edge behaves as IDLE.
- CE=1 in the same cycle as a load in IDLE: the load is still taken.

## Structure
- Shared package piso_pkg holds:
  - typedef piso_state_t {IDLE, SHIFT};
  - a cnt_w(WIDTH) constant function returning clog2(WIDTH) with a minimum of 1.
- Single module with no sub-modules. The counter and the shift register are small enough to be written inline.

## Test plan
- WIDTH=8, MSB_FIRST=1: load 8'hA5, CE=0 → Y=1,0,1,0,0,1,0,1 on consecutive cycles; Yn is the complement; LAST only on the 8th bit; BUSY for 8 cycles; D_READY=1 afterwards.
- MSB_FIRST=0: load 8'h1E → Y=0,1,1,1,1,0,0,0.
- Stall: load 8'hF0, CE=1 for 3 cycles after bit 2 → Y holds 1 for those cycles; LAST arrives 3 cycles later than without the stall.
- Back-to-back: D_VALID held high with 8'hFF then 8'h00 → 16 contiguous bits (eight 1s, then eight 0s); D_READY pulses only on the load cycle and on the last bit; BUSY never drops between the two words.
- Reset mid-frame: load 8'hFF, assert MR after bit 3 → Y=0, Yn=1, BUSY=0, LAST never asserted; the next load of 8'h81 serialises correctly.
- IDLE cascade: no load, CE=0, Ds=1 for 8 cycles from reset → Y goes from 0 to 1 on the 8th shift; CNT and BUSY do not change.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parametrised PISO shift register.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Counter width for a frame of 'width' bits, never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_n.sv
// Parallel-in/serial-out shift register with valid/ready load, selectable bit
// order and a frame counter; keeps the 165-style CE/Ds/Y/Yn cascade signals.
module piso_shift_n
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             CE,
    input  logic             Ds,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic             Y,
    output logic             Yn,
    output logic             BUSY,
    output logic             LAST
);

    localparam int              CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    piso_state_t      state;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    // Ds always enters at the end opposite the output end.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                   input logic             ds);
        if (MSB_FIRST)
            return {cur[WIDTH-2:0], ds};
        else
            return {ds, cur[WIDTH-1:1]};
    endfunction

    assign cnt_zero = (cnt == '0);

    assign D_READY = (state == IDLE) || ((state == SHIFT) && cnt_zero && !CE);
    assign BUSY    = (state == SHIFT);
    assign LAST    = (state == SHIFT) && cnt_zero;

    assign Y  = MSB_FIRST ? q[WIDTH-1] : q[0];
    assign Yn = ~Y;

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state <= IDLE;
            q     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (D_VALID) begin
                        q     <= D;
                        cnt   <= CNT_LOAD;
                        state <= SHIFT;
                    end else if (!CE) begin
                        q <= shift_in(q, Ds);
                    end
                end
                SHIFT: begin
                    if (!CE) begin
                        if (!cnt_zero) begin
                            q   <= shift_in(q, Ds);
                            cnt <= cnt - CNT_W'(1);
                        end else if (D_VALID) begin
                            // Back-to-back: next word replaces the last bit with no gap.
                            q   <= D;
                            cnt <= CNT_LOAD;
                        end else begin
                            q     <= shift_in(q, Ds);
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_n.sv
// Directed bench for piso_shift_n: one MSB-first and one LSB-first instance on shared inputs.
module tb_piso_shift_n;

    logic       CP = 1'b0;
    logic       MR = 1'b1;
    logic       CE = 1'b1;
    logic       Ds = 1'b0;
    logic [7:0] D  = 8'h00;
    logic       D_VALID = 1'b0;

    logic rdy_m, y_m, yn_m, busy_m, last_m;
    logic rdy_l, y_l, yn_l, busy_l, last_l;

    int n_checks = 0;
    int n_pass   = 0;

    piso_shift_n #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .CP(CP), .MR(MR), .CE(CE), .Ds(Ds), .D(D), .D_VALID(D_VALID),
        .D_READY(rdy_m), .Y(y_m), .Yn(yn_m), .BUSY(busy_m), .LAST(last_m)
    );

    piso_shift_n #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .CP(CP), .MR(MR), .CE(CE), .Ds(Ds), .D(D), .D_VALID(D_VALID),
        .D_READY(rdy_l), .Y(y_l), .Yn(yn_l), .BUSY(busy_l), .LAST(last_l)
    );

    always #5 CP = ~CP;

    task automatic do_reset();
        @(negedge CP);
        MR = 1'b1; CE = 1'b1; D_VALID = 1'b0; Ds = 1'b0;
        @(negedge CP);
        MR = 1'b0;
    endtask

    task automatic test_reset();
        MR = 1'b1;
        #1;
        n_checks++; if (y_m !== 1'b0)    $display("FAIL reset_y got %b want 0", y_m);    else n_pass++;
        n_checks++; if (yn_m !== 1'b1)   $display("FAIL reset_yn got %b want 1", yn_m);  else n_pass++;
        n_checks++; if (busy_m !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_m); else n_pass++;
        n_checks++; if (last_m !== 1'b0) $display("FAIL reset_last got %b want 0", last_m); else n_pass++;
        n_checks++; if (rdy_m !== 1'b1)  $display("FAIL reset_ready got %b want 1", rdy_m); else n_pass++;
        n_checks++; if (y_l !== 1'b0)    $display("FAIL reset_y_lsb got %b want 0", y_l);   else n_pass++;
        @(negedge CP);
        MR = 1'b0;
    endtask

    // Loads w and checks one full unstalled frame; starts and ends at a negedge in IDLE.
    task automatic run_frame(input logic [7:0] w, input bit lsb);
        logic exp_y;
        logic act_y, act_yn, act_busy, act_last;
        D = w; D_VALID = 1'b1; CE = 1'b0;
        #1;
        n_checks++; if ((lsb ? rdy_l : rdy_m) !== 1'b1)
            $display("FAIL frame_ready_load got %b want 1", lsb ? rdy_l : rdy_m); else n_pass++;
        @(negedge CP);
        D_VALID = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_y    = lsb ? w[i] : w[7-i];
            act_y    = lsb ? y_l : y_m;
            act_yn   = lsb ? yn_l : yn_m;
            act_busy = lsb ? busy_l : busy_m;
            act_last = lsb ? last_l : last_m;
            n_checks++; if (act_y !== exp_y)
                $display("FAIL frame_y word %h bit %0d got %b want %b", w, i, act_y, exp_y); else n_pass++;
            n_checks++; if (act_yn !== ~exp_y)
                $display("FAIL frame_yn word %h bit %0d got %b want %b", w, i, act_yn, ~exp_y); else n_pass++;
            n_checks++; if (act_busy !== 1'b1)
                $display("FAIL frame_busy word %h bit %0d got %b want 1", w, i, act_busy); else n_pass++;
            n_checks++; if (act_last !== (i == 7))
                $display("FAIL frame_last word %h bit %0d got %b want %b", w, i, act_last, (i == 7)); else n_pass++;
            @(negedge CP);
        end
        #1;
        n_checks++; if ((lsb ? busy_l : busy_m) !== 1'b0)
            $display("FAIL frame_busy_end got %b want 0", lsb ? busy_l : busy_m); else n_pass++;
        n_checks++; if ((lsb ? rdy_l : rdy_m) !== 1'b1)
            $display("FAIL frame_ready_end got %b want 1", lsb ? rdy_l : rdy_m); else n_pass++;
        CE = 1'b1;
    endtask

    task automatic test_msb_first();
        do_reset();
        run_frame(8'hA5, 1'b0);
    endtask

    task automatic test_lsb_first();
        do_reset();
        run_frame(8'h1E, 1'b1);
    endtask

    task automatic test_stall();
        bit ce_seq [11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        bit y_seq  [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        do_reset();
        D = 8'hF0; D_VALID = 1'b1; CE = 1'b0;
        @(negedge CP);
        D_VALID = 1'b0;
        for (int i = 0; i < 11; i++) begin
            CE = ce_seq[i];
            #1;
            n_checks++; if (y_m !== y_seq[i])
                $display("FAIL stall_y cycle %0d got %b want %b", i, y_m, y_seq[i]); else n_pass++;
            n_checks++; if (last_m !== (i == 10))
                $display("FAIL stall_last cycle %0d got %b want %b", i, last_m, (i == 10)); else n_pass++;
            n_checks++; if (busy_m !== 1'b1)
                $display("FAIL stall_busy cycle %0d got %b want 1", i, busy_m); else n_pass++;
            @(negedge CP);
        end
        #1;
        n_checks++; if (busy_m !== 1'b0) $display("FAIL stall_busy_end got %b want 0", busy_m); else n_pass++;
        CE = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic exp_y;
        do_reset();
        D = 8'hFF; D_VALID = 1'b1; CE = 1'b0;
        @(negedge CP);
        D = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) D_VALID = 1'b0;
            #1;
            exp_y = (i < 8);
            n_checks++; if (y_m !== exp_y)
                $display("FAIL b2b_y bit %0d got %b want %b", i, y_m, exp_y); else n_pass++;
            n_checks++; if (rdy_m !== (i == 7 || i == 15))
                $display("FAIL b2b_ready bit %0d got %b want %b", i, rdy_m, (i == 7 || i == 15)); else n_pass++;
            n_checks++; if (busy_m !== 1'b1)
                $display("FAIL b2b_busy bit %0d got %b want 1", i, busy_m); else n_pass++;
            @(negedge CP);
        end
        #1;
        n_checks++; if (busy_m !== 1'b0) $display("FAIL b2b_busy_end got %b want 0", busy_m); else n_pass++;
        CE = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        D = 8'hFF; D_VALID = 1'b1; CE = 1'b0;
        @(negedge CP);
        D_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (last_m !== 1'b0)
                $display("FAIL abort_last_pre bit %0d got %b want 0", i, last_m); else n_pass++;
            @(negedge CP);
        end
        MR = 1'b1;
        #1;
        n_checks++; if (y_m !== 1'b0)    $display("FAIL abort_y got %b want 0", y_m);       else n_pass++;
        n_checks++; if (yn_m !== 1'b1)   $display("FAIL abort_yn got %b want 1", yn_m);     else n_pass++;
        n_checks++; if (busy_m !== 1'b0) $display("FAIL abort_busy got %b want 0", busy_m); else n_pass++;
        n_checks++; if (last_m !== 1'b0) $display("FAIL abort_last got %b want 0", last_m); else n_pass++;
        @(negedge CP);
        MR = 1'b0;
        run_frame(8'h81, 1'b0);
    endtask

    task automatic test_idle_cascade();
        do_reset();
        D_VALID = 1'b0; CE = 1'b0; Ds = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CP);
            #1;
            n_checks++; if (y_m !== (k == 8))
                $display("FAIL cascade_y shift %0d got %b want %b", k, y_m, (k == 8)); else n_pass++;
            n_checks++; if (busy_m !== 1'b0)
                $display("FAIL cascade_busy shift %0d got %b want 0", k, busy_m); else n_pass++;
            n_checks++; if (last_m !== 1'b0)
                $display("FAIL cascade_last shift %0d got %b want 0", k, last_m); else n_pass++;
        end
        CE = 1'b1; Ds = 1'b0;
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle_cascade();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
